core_pipe_mem: RTL and testbench
================================

CORE_PIPE_MEM -- requirements
Module: core_pipe_mem

Interface
REQ-001 Parameter: XLEN, 64, GPR/data width (XL = XLEN-1).
REQ-002 Port: g_clk  in  1  global clock; the only clock.
REQ-003 Port: g_reset  in  1  asynchronous, active-high reset.
REQ-004 Port: s2_valid  in  1  execute-stage instruction valid.
REQ-005 Port: s2_ready  out  1  this stage accepts the s2 instruction.
REQ-006 Port: s2_pc, s2_n_pc, s2_instr  in  XLEN,XLEN,32  PC, next PC, instruction word.
REQ-007 Port: s2_wdata  in  XLEN  ALU result; the effective address for LSU ops.
REQ-008 Port: s2_rs2  in  XLEN  store data.
REQ-009 Port: s2_rd, s2_lsu_op, s2_csr_op, s2_csr_addr, s2_cfu_op, s2_wb_op, s2_trap  in  as package widths  control fields.
REQ-010 Port: s3_valid, s3_full  out  1  writeback hand-over valid; writeback slot occupied.
REQ-011 Port: s3_ready  in  1  writeback accepts a new instruction.
REQ-012 Port: s3_<field>  out  same as s2_<field>  registered copy of every s2 field except s2_rs2; s3_trap is s2_trap OR the misalign trap.
REQ-013 Port: flush  in  1  writeback control-flow change acknowledged.
REQ-014 Port: dmem_req, dmem_wen  out  1  memory request; write enable.
REQ-015 Port: dmem_addr, dmem_strb, dmem_wdata  out  MEM_ADDR_W, 8, 64  doubleword-aligned address, byte strobe, positioned write data.
REQ-016 Port: dmem_gnt  in  1  request accepted.

Function
REQ-017 Stage holds one pipeline register (s3_*) plus FSM {IDLE, REQ, DRAIN}.
REQ-018 lsu = s2_valid and (LOAD or STORE) and not s2_trap and not misaligned.
REQ-019 IDLE: dmem_req = lsu and slot free (not s3_full, or s3_ready); on req without gnt go to REQ.
REQ-020 REQ: dmem_req held high with addr/wen/strb/wdata stable until dmem_gnt; on gnt return to IDLE.
REQ-021 s2_ready = slot free and (not lsu, or dmem_req and dmem_gnt).
REQ-022 On s2_valid and s2_ready: capture the s2 fields into s3_* next cycle, and set s3_full.
REQ-023 s3_full clears when s3_ready is high and no capture occurs that cycle; capture and release in the same cycle keeps s3_full high with the new fields.
REQ-024 s3_valid = s3_full; minimum latency s2 to s3 is 1 cycle; gnt wait adds 1 cycle per stall cycle.
REQ-025 dmem_addr = s2_wdata with bits [2:0] zeroed; dmem_wen = STORE.
REQ-026 dmem_strb: byte 0x01, half 0x03, word 0x0F, double 0xFF, each shifted left by addr[2:0].
REQ-027 dmem_wdata = s2_rs2 shifted left by 8*addr[2:0], truncated to 64 bits.
REQ-028 Misaligned means half with addr[0] set, word with addr[1:0] nonzero, or double with addr[2:0] nonzero.
REQ-029 Flush while IDLE: clear s3_full and drop any capture that cycle.
REQ-030 Flush while REQ: go to DRAIN, hold the request until gnt, then go to IDLE. The granted instruction is not captured. s2_ready is low in DRAIN.
REQ-031 Flush and gnt in the same cycle: the request completes, its instruction is discarded, and the FSM goes to IDLE.

Reset
REQ-032 Reset values: FSM IDLE; s3_full, s3_valid, dmem_req and s2_ready = 0; all s3_* data fields = 0.
REQ-033 Reset asserted mid-REQ abandons the request immediately; dmem_req is 0 while g_reset is high.

Configuration
REQ-034 Macro CORE_MISALIGN_TRAP_EN defined: a misaligned LSU op issues no request and is captured with s3_trap = 1 and s3_trap_cause = load/store address-misaligned.
REQ-035 Macro CORE_MISALIGN_TRAP_EN absent: misaligned is tied to 0; the request issues with the low address bits dropped, and no trap is raised.

Structure
REQ-036 Shared package core_common holds LSU_OP_*, CSR_OP_*, WB_OP_*, CF_CAUSE_* encodings, the _R widths and MEM_ADDR_W.
REQ-037 One sub-module, core_lsu_align, contains the strobe, write-data positioning and misalign detection (combinational).

Verification
REQ-038 SW, addr 0x1004, rs2 0xDEADBEEF, gnt same cycle -> strb 0xF0, wdata 0xDEADBEEF00000000, addr 0x1000, s3_valid next cycle.
REQ-039 LB, addr 0x2003, gnt after 3 cycles -> dmem_req held 4 cycles with stable addr 0x2000/strb 0x08; s2_ready high only in the gnt cycle.
REQ-040 Back-to-back ALU ops with s3_ready stuck low for 2 cycles -> s2_ready low; s3 fields unchanged; no dmem_req.
REQ-041 Flush during REQ, gnt 2 cycles later -> request not retracted; s3_full stays 0; FSM returns to IDLE.
REQ-042 LW addr 0x3002, macro defined -> no dmem_req; s3_trap = 1; with macro absent -> request at 0x3000.
REQ-043 g_reset asserted while in REQ -> dmem_req and s3_full = 0 in the same cycle (asynchronous).

Source files
------------

// File: rtl/core_pipe_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : core_common                                                     |
// | Purpose  : Shared encodings and field widths for the core pipeline:        |
// |            LSU/CSR/WB operation codes, trap causes, control-field widths,  |
// |            data-memory address width and the memory-stage FSM states.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package core_common;

  // Control-field widths
  localparam int RD_R       = 5;
  localparam int LSU_OP_R   = 4;
  localparam int CSR_OP_R   = 3;
  localparam int CSR_ADDR_R = 12;
  localparam int CFU_OP_R   = 3;
  localparam int WB_OP_R    = 2;
  localparam int CF_CAUSE_R = 6;
  localparam int MEM_ADDR_W = 32;

  // LSU op layout: [3] store, [2] load, [1:0] log2 of the access size in bytes
  localparam logic [LSU_OP_R-1:0] LSU_OP_NONE = 4'b0000;
  localparam logic [LSU_OP_R-1:0] LSU_OP_LB   = 4'b0100;
  localparam logic [LSU_OP_R-1:0] LSU_OP_LH   = 4'b0101;
  localparam logic [LSU_OP_R-1:0] LSU_OP_LW   = 4'b0110;
  localparam logic [LSU_OP_R-1:0] LSU_OP_LD   = 4'b0111;
  localparam logic [LSU_OP_R-1:0] LSU_OP_SB   = 4'b1000;
  localparam logic [LSU_OP_R-1:0] LSU_OP_SH   = 4'b1001;
  localparam logic [LSU_OP_R-1:0] LSU_OP_SW   = 4'b1010;
  localparam logic [LSU_OP_R-1:0] LSU_OP_SD   = 4'b1011;

  localparam logic [CSR_OP_R-1:0] CSR_OP_NONE = 3'd0;
  localparam logic [CSR_OP_R-1:0] CSR_OP_RW   = 3'd1;
  localparam logic [CSR_OP_R-1:0] CSR_OP_RS   = 3'd2;
  localparam logic [CSR_OP_R-1:0] CSR_OP_RC   = 3'd3;

  localparam logic [WB_OP_R-1:0] WB_OP_NONE = 2'd0;
  localparam logic [WB_OP_R-1:0] WB_OP_ALU  = 2'd1;
  localparam logic [WB_OP_R-1:0] WB_OP_LSU  = 2'd2;
  localparam logic [WB_OP_R-1:0] WB_OP_CSR  = 2'd3;

  localparam logic [CF_CAUSE_R-1:0] CF_CAUSE_NONE        = 6'd0;
  localparam logic [CF_CAUSE_R-1:0] CF_CAUSE_LD_MISALIGN = 6'd4;
  localparam logic [CF_CAUSE_R-1:0] CF_CAUSE_ST_MISALIGN = 6'd6;

  // Memory-stage FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } mem_state_e;

  function automatic logic lsu_is_load(input logic [LSU_OP_R-1:0] op);
    return op[2];
  endfunction

  function automatic logic lsu_is_store(input logic [LSU_OP_R-1:0] op);
    return op[3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_pipe_mem_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_lsu_align                                                  |
// | Purpose  : Combinational LSU lane alignment: byte strobe, store-data      |
// |            positioning within the 64-bit doubleword, misalign detection.   |
// | Ports    : size     in  2     log2 access size (0=B,1=H,2=W,3=D)           |
// |            addr_lo  in  3     effective address bits [2:0]                 |
// |            rs2      in  XLEN  store data                                   |
// |            strb     out 8     byte strobe                                  |
// |            wdata    out 64    write data shifted onto its byte lanes       |
// |            misaligned out 1   access crosses its natural alignment         |
// | Config   : CORE_MISALIGN_TRAP_EN - when undefined misaligned is tied to 0  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module core_lsu_align #(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] rs2,
  output logic [7:0]      strb,
  output logic [63:0]     wdata,
  output logic            misaligned
);

  logic [7:0] base_strb;

  always_comb begin
    base_strb = 8'h01;
    case (size)
      2'd0:    base_strb = 8'h01;
      2'd1:    base_strb = 8'h03;
      2'd2:    base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
  end

  // Lanes that fall off the top of the doubleword are simply dropped.
  assign strb  = base_strb << addr_lo;
  assign wdata = 64'(rs2) << {addr_lo, 3'b000};

`ifdef CORE_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_lo[0];
      2'd2:    misaligned = |addr_lo[1:0];
      default: misaligned = |addr_lo;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/core_pipe_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_pipe_mem                                                   |
// | Purpose  : Memory stage. Issues data-memory requests for loads/stores,     |
// |            waits for grant, and hands every instruction to writeback via   |
// |            the s3_* pipeline register.                                     |
// | Ports    : g_clk/g_reset      clock, async active-high reset               |
// |            s2_*               execute-stage instruction + valid/ready      |
// |            s3_*               writeback hand-over register + valid/ready   |
// |            flush              writeback control-flow change acknowledged   |
// |            dmem_*             data-memory request channel (req/gnt)        |
// | Config   : CORE_MISALIGN_TRAP_EN - misaligned LSU ops trap instead of      |
// |            issuing (default: low address bits are dropped, no trap)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module core_pipe_mem
  import core_common::*;
#(
  parameter int XLEN = 64
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  s2_valid,
  output logic                  s2_ready,
  input  logic [XLEN-1:0]       s2_pc,
  input  logic [XLEN-1:0]       s2_n_pc,
  input  logic [31:0]           s2_instr,
  input  logic [XLEN-1:0]       s2_wdata,
  input  logic [XLEN-1:0]       s2_rs2,
  input  logic [RD_R-1:0]       s2_rd,
  input  logic [LSU_OP_R-1:0]   s2_lsu_op,
  input  logic [CSR_OP_R-1:0]   s2_csr_op,
  input  logic [CSR_ADDR_R-1:0] s2_csr_addr,
  input  logic [CFU_OP_R-1:0]   s2_cfu_op,
  input  logic [WB_OP_R-1:0]    s2_wb_op,
  input  logic                  s2_trap,
  output logic                  s3_valid,
  output logic                  s3_full,
  input  logic                  s3_ready,
  output logic [XLEN-1:0]       s3_pc,
  output logic [XLEN-1:0]       s3_n_pc,
  output logic [31:0]           s3_instr,
  output logic [XLEN-1:0]       s3_wdata,
  output logic [RD_R-1:0]       s3_rd,
  output logic [LSU_OP_R-1:0]   s3_lsu_op,
  output logic [CSR_OP_R-1:0]   s3_csr_op,
  output logic [CSR_ADDR_R-1:0] s3_csr_addr,
  output logic [CFU_OP_R-1:0]   s3_cfu_op,
  output logic [WB_OP_R-1:0]    s3_wb_op,
  output logic                  s3_trap,
  output logic [CF_CAUSE_R-1:0] s3_trap_cause,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic                  dmem_wen,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic [7:0]            dmem_strb,
  output logic [63:0]           dmem_wdata,
  input  logic                  dmem_gnt
);

  mem_state_e state_q, state_d;

  logic                  s3_full_q, s3_full_d;
  logic [XLEN-1:0]       s3_pc_q, s3_pc_d, s3_n_pc_q, s3_n_pc_d, s3_wdata_q, s3_wdata_d;
  logic [31:0]           s3_instr_q, s3_instr_d;
  logic [RD_R-1:0]       s3_rd_q, s3_rd_d;
  logic [LSU_OP_R-1:0]   s3_lsu_op_q, s3_lsu_op_d;
  logic [CSR_OP_R-1:0]   s3_csr_op_q, s3_csr_op_d;
  logic [CSR_ADDR_R-1:0] s3_csr_addr_q, s3_csr_addr_d;
  logic [CFU_OP_R-1:0]   s3_cfu_op_q, s3_cfu_op_d;
  logic [WB_OP_R-1:0]    s3_wb_op_q, s3_wb_op_d;
  logic                  s3_trap_q, s3_trap_d;
  logic [CF_CAUSE_R-1:0] s3_cause_q, s3_cause_d;

  // Snapshot of the outstanding request; s2 may move on after a flush.
  logic [MEM_ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]            req_strb_q, req_strb_d;
  logic [63:0]           req_wdata_q, req_wdata_d;
  logic                  req_wen_q, req_wen_d;

  logic                  is_load, is_store, align_mis, misaligned, lsu;
  logic                  slot_free, capture, req_int, ready_int;
  logic [MEM_ADDR_W-1:0] live_addr;
  logic [7:0]            live_strb;
  logic [63:0]           live_wdata;

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .size       (s2_lsu_op[1:0]),
    .addr_lo    (s2_wdata[2:0]),
    .rs2        (s2_rs2),
    .strb       (live_strb),
    .wdata      (live_wdata),
    .misaligned (align_mis)
  );

  assign is_load    = lsu_is_load(s2_lsu_op);
  assign is_store   = lsu_is_store(s2_lsu_op);
  assign misaligned = s2_valid && (is_load || is_store) && align_mis;
  assign lsu        = s2_valid && (is_load || is_store) && !s2_trap && !misaligned;
  assign slot_free  = !s3_full_q || s3_ready;
  assign live_addr  = {s2_wdata[MEM_ADDR_W-1:3], 3'b000};

  always_comb begin
    state_d   = state_q;
    req_int   = 1'b0;
    ready_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A flushed (wrong-path) op must never reach memory.
        req_int   = lsu && slot_free && !flush;
        ready_int = slot_free && (!lsu || (req_int && dmem_gnt));
        if (req_int && !dmem_gnt) state_d = ST_REQ;
      end
      ST_REQ: begin
        req_int   = 1'b1;
        ready_int = slot_free && dmem_gnt;
        if (dmem_gnt)   state_d = ST_IDLE;
        else if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Request cannot be retracted; wait out the grant and discard it.
        req_int = 1'b1;
        if (dmem_gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign capture = s2_valid && ready_int && !flush;

  always_comb begin
    s3_full_d     = s3_full_q;
    s3_pc_d       = s3_pc_q;
    s3_n_pc_d     = s3_n_pc_q;
    s3_instr_d    = s3_instr_q;
    s3_wdata_d    = s3_wdata_q;
    s3_rd_d       = s3_rd_q;
    s3_lsu_op_d   = s3_lsu_op_q;
    s3_csr_op_d   = s3_csr_op_q;
    s3_csr_addr_d = s3_csr_addr_q;
    s3_cfu_op_d   = s3_cfu_op_q;
    s3_wb_op_d    = s3_wb_op_q;
    s3_trap_d     = s3_trap_q;
    s3_cause_d    = s3_cause_q;
    if (flush)         s3_full_d = 1'b0;
    else if (capture)  s3_full_d = 1'b1;
    else if (s3_ready) s3_full_d = 1'b0;
    if (capture) begin
      s3_pc_d       = s2_pc;
      s3_n_pc_d     = s2_n_pc;
      s3_instr_d    = s2_instr;
      s3_wdata_d    = s2_wdata;
      s3_rd_d       = s2_rd;
      s3_lsu_op_d   = s2_lsu_op;
      s3_csr_op_d   = s2_csr_op;
      s3_csr_addr_d = s2_csr_addr;
      s3_cfu_op_d   = s2_cfu_op;
      s3_wb_op_d    = s2_wb_op;
      s3_trap_d     = s2_trap || misaligned;
      s3_cause_d    = !misaligned ? CF_CAUSE_NONE :
                      is_store    ? CF_CAUSE_ST_MISALIGN : CF_CAUSE_LD_MISALIGN;
    end
  end

  always_comb begin
    req_addr_d  = req_addr_q;
    req_strb_d  = req_strb_q;
    req_wdata_d = req_wdata_q;
    req_wen_d   = req_wen_q;
    if (state_q == ST_IDLE) begin
      req_addr_d  = live_addr;
      req_strb_d  = live_strb;
      req_wdata_d = live_wdata;
      req_wen_d   = is_store;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q       <= ST_IDLE;
      s3_full_q     <= 1'b0;
      s3_pc_q       <= '0;
      s3_n_pc_q     <= '0;
      s3_instr_q    <= '0;
      s3_wdata_q    <= '0;
      s3_rd_q       <= '0;
      s3_lsu_op_q   <= '0;
      s3_csr_op_q   <= '0;
      s3_csr_addr_q <= '0;
      s3_cfu_op_q   <= '0;
      s3_wb_op_q    <= '0;
      s3_trap_q     <= 1'b0;
      s3_cause_q    <= '0;
      req_addr_q    <= '0;
      req_strb_q    <= '0;
      req_wdata_q   <= '0;
      req_wen_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      s3_full_q     <= s3_full_d;
      s3_pc_q       <= s3_pc_d;
      s3_n_pc_q     <= s3_n_pc_d;
      s3_instr_q    <= s3_instr_d;
      s3_wdata_q    <= s3_wdata_d;
      s3_rd_q       <= s3_rd_d;
      s3_lsu_op_q   <= s3_lsu_op_d;
      s3_csr_op_q   <= s3_csr_op_d;
      s3_csr_addr_q <= s3_csr_addr_d;
      s3_cfu_op_q   <= s3_cfu_op_d;
      s3_wb_op_q    <= s3_wb_op_d;
      s3_trap_q     <= s3_trap_d;
      s3_cause_q    <= s3_cause_d;
      req_addr_q    <= req_addr_d;
      req_strb_q    <= req_strb_d;
      req_wdata_q   <= req_wdata_d;
      req_wen_q     <= req_wen_d;
    end
  end

  // Handshake outputs are masked by reset directly so an in-flight request
  // drops in the same cycle reset is raised, not at the next clock edge.
  assign dmem_req   = req_int && !g_reset;
  assign s2_ready   = ready_int && !g_reset;
  assign dmem_addr  = (state_q == ST_IDLE) ? live_addr  : req_addr_q;
  assign dmem_strb  = (state_q == ST_IDLE) ? live_strb  : req_strb_q;
  assign dmem_wdata = (state_q == ST_IDLE) ? live_wdata : req_wdata_q;
  assign dmem_wen   = (state_q == ST_IDLE) ? is_store   : req_wen_q;

  assign s3_full       = s3_full_q;
  assign s3_valid      = s3_full_q;
  assign s3_pc         = s3_pc_q;
  assign s3_n_pc       = s3_n_pc_q;
  assign s3_instr      = s3_instr_q;
  assign s3_wdata      = s3_wdata_q;
  assign s3_rd         = s3_rd_q;
  assign s3_lsu_op     = s3_lsu_op_q;
  assign s3_csr_op     = s3_csr_op_q;
  assign s3_csr_addr   = s3_csr_addr_q;
  assign s3_cfu_op     = s3_cfu_op_q;
  assign s3_wb_op      = s3_wb_op_q;
  assign s3_trap       = s3_trap_q;
  assign s3_trap_cause = s3_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_core_pipe_mem                                                |
// | Purpose  : Self-checking bench for core_pipe_mem: table of single-cycle    |
// |            LSU/ALU vectors plus hand-written grant-stall, back-pressure,   |
// |            flush and asynchronous-reset sequences.                         |
// | Config   : CORE_MISALIGN_TRAP_EN selects the misaligned-op expectations    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_core_pipe_mem;
  import core_common::*;

  localparam int XLEN = 64;

  logic                  g_clk, g_reset;
  logic                  s2_valid, s2_ready;
  logic [XLEN-1:0]       s2_pc, s2_n_pc, s2_wdata, s2_rs2;
  logic [31:0]           s2_instr;
  logic [RD_R-1:0]       s2_rd;
  logic [LSU_OP_R-1:0]   s2_lsu_op;
  logic [CSR_OP_R-1:0]   s2_csr_op;
  logic [CSR_ADDR_R-1:0] s2_csr_addr;
  logic [CFU_OP_R-1:0]   s2_cfu_op;
  logic [WB_OP_R-1:0]    s2_wb_op;
  logic                  s2_trap;
  logic                  s3_valid, s3_full, s3_ready;
  logic [XLEN-1:0]       s3_pc, s3_n_pc, s3_wdata;
  logic [31:0]           s3_instr;
  logic [RD_R-1:0]       s3_rd;
  logic [LSU_OP_R-1:0]   s3_lsu_op;
  logic [CSR_OP_R-1:0]   s3_csr_op;
  logic [CSR_ADDR_R-1:0] s3_csr_addr;
  logic [CFU_OP_R-1:0]   s3_cfu_op;
  logic [WB_OP_R-1:0]    s3_wb_op;
  logic                  s3_trap;
  logic [CF_CAUSE_R-1:0] s3_trap_cause;
  logic                  flush;
  logic                  dmem_req, dmem_wen, dmem_gnt;
  logic [MEM_ADDR_W-1:0] dmem_addr;
  logic [7:0]            dmem_strb;
  logic [63:0]           dmem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  core_pipe_mem #(.XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s2_valid(s2_valid), .s2_ready(s2_ready),
    .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_instr(s2_instr),
    .s2_wdata(s2_wdata), .s2_rs2(s2_rs2), .s2_rd(s2_rd),
    .s2_lsu_op(s2_lsu_op), .s2_csr_op(s2_csr_op), .s2_csr_addr(s2_csr_addr),
    .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op), .s2_trap(s2_trap),
    .s3_valid(s3_valid), .s3_full(s3_full), .s3_ready(s3_ready),
    .s3_pc(s3_pc), .s3_n_pc(s3_n_pc), .s3_instr(s3_instr),
    .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op),
    .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr), .s3_cfu_op(s3_cfu_op),
    .s3_wb_op(s3_wb_op), .s3_trap(s3_trap), .s3_trap_cause(s3_trap_cause),
    .flush(flush),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [LSU_OP_R-1:0] op;
    logic [63:0]         addr;
    logic [63:0]         rs2;
    logic                trap_in;
    logic                exp_req;
    logic                exp_wen;
    logic [63:0]         exp_addr;
    logic [7:0]          exp_strb;
    logic [63:0]         exp_wdata;
    logic                exp_trap;
    logic [5:0]          exp_cause;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s2_valid = 1'b0; s2_pc = '0; s2_n_pc = '0; s2_instr = '0;
    s2_wdata = '0; s2_rs2 = '0; s2_rd = '0; s2_lsu_op = LSU_OP_NONE;
    s2_csr_op = CSR_OP_NONE; s2_csr_addr = '0; s2_cfu_op = '0;
    s2_wb_op = WB_OP_NONE; s2_trap = 1'b0;
    s3_ready = 1'b1; flush = 1'b0; dmem_gnt = 1'b0;
  endtask

  task automatic drive_op(input logic [LSU_OP_R-1:0] op, input logic [63:0] addr,
                          input logic [63:0] rs2, input logic [63:0] pc);
    s2_valid = 1'b1; s2_lsu_op = op; s2_wdata = addr; s2_rs2 = rs2;
    s2_pc = pc; s2_n_pc = pc + 64'd4; s2_instr = 32'h13 + 32'(pc);
    s2_wb_op = (op == LSU_OP_NONE) ? WB_OP_ALU : WB_OP_LSU;
  endtask

  initial begin
    // {op, addr, rs2, trap_in, req, wen, addr, strb, wdata, trap, cause}
    vecs[0] = '{LSU_OP_SW, 64'h1004, 64'hDEADBEEF, 1'b0, 1'b1, 1'b1, 64'h1000, 8'hF0, 64'hDEADBEEF_00000000, 1'b0, 6'd0};
    vecs[1] = '{LSU_OP_SB, 64'h0007, 64'h11223344556677AB, 1'b0, 1'b1, 1'b1, 64'h0, 8'h80, 64'hAB000000_00000000, 1'b0, 6'd0};
    vecs[2] = '{LSU_OP_SH, 64'h2002, 64'hCAFE, 1'b0, 1'b1, 1'b1, 64'h2000, 8'h0C, 64'h00000000_CAFE0000, 1'b0, 6'd0};
    vecs[3] = '{LSU_OP_SD, 64'h0010, 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b1, 64'h10, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 6'd0};
    vecs[4] = '{LSU_OP_LD, 64'h0008, 64'h0, 1'b0, 1'b1, 1'b0, 64'h8, 8'hFF, 64'h0, 1'b0, 6'd0};
    vecs[5] = '{LSU_OP_NONE, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b0, 6'd0};
`ifdef CORE_MISALIGN_TRAP_EN
    vecs[6] = '{LSU_OP_LW, 64'h3002, 64'h55, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 6'd4};
`else
    vecs[6] = '{LSU_OP_LW, 64'h3002, 64'h55, 1'b0, 1'b1, 1'b0, 64'h3000, 8'h3C, 64'h550000, 1'b0, 6'd0};
`endif
    vecs[7] = '{LSU_OP_LH, 64'h0040, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 6'd0};

    // Reset state, with a live store presented to prove the request is masked
    g_reset = 1'b1;
    idle_inputs();
    drive_op(LSU_OP_SW, 64'h1004, 64'h1, 64'h40);
    repeat (2) @(negedge g_clk);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_s2_ready", s2_ready, 0);
    chk("rst_s3_full", s3_full, 0);
    chk("rst_s3_valid", s3_valid, 0);
    chk("rst_s3_pc", s3_pc, 0);
    chk("rst_s3_trap", s3_trap, 0);
    g_reset = 1'b0;
    idle_inputs();
    @(negedge g_clk);

    // Table: each vector granted in its issue cycle, writeback always ready
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].op, vecs[i].addr, vecs[i].rs2, 64'h1000 + 64'(i) * 4);
      s2_trap  = vecs[i].trap_in;
      dmem_gnt = 1'b1;
      #1;
      chk($sformatf("v%0d_req", i), dmem_req, vecs[i].exp_req);
      chk($sformatf("v%0d_s2_ready", i), s2_ready, 1);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_strb", i), dmem_strb, vecs[i].exp_strb);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
        chk($sformatf("v%0d_wen", i), dmem_wen, vecs[i].exp_wen);
      end
      @(posedge g_clk); #1;
      chk($sformatf("v%0d_s3_valid", i), s3_valid, 1);
      chk($sformatf("v%0d_s3_pc", i), s3_pc, 64'h1000 + 64'(i) * 4);
      chk($sformatf("v%0d_s3_wdata", i), s3_wdata, vecs[i].addr);
      chk($sformatf("v%0d_s3_trap", i), s3_trap, vecs[i].exp_trap);
      chk($sformatf("v%0d_s3_cause", i), s3_trap_cause, vecs[i].exp_cause);
      @(negedge g_clk);
    end
    idle_inputs();
    @(negedge g_clk);
    chk("drain_s3_full", s3_full, 0);

    // LB at 0x2003, grant arrives in the fourth request cycle
    drive_op(LSU_OP_LB, 64'h2003, 64'h0, 64'h200);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_gnt = 1'b1;
      #1;
      chk($sformatf("lb_c%0d_req", c), dmem_req, 1);
      chk($sformatf("lb_c%0d_addr", c), dmem_addr, 64'h2000);
      chk($sformatf("lb_c%0d_strb", c), dmem_strb, 8'h08);
      chk($sformatf("lb_c%0d_s2_ready", c), s2_ready, (c == 3) ? 1 : 0);
      @(negedge g_clk);
    end
    chk("lb_s3_valid", s3_valid, 1);
    chk("lb_s3_pc", s3_pc, 64'h200);
    idle_inputs();

    // Back-to-back ALU ops, writeback stalled for 2 cycles
    drive_op(LSU_OP_NONE, 64'h77, 64'h0, 64'h300);
    @(negedge g_clk);
    chk("alu0_s3_pc", s3_pc, 64'h300);
    drive_op(LSU_OP_NONE, 64'h78, 64'h0, 64'h304);
    s3_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp_c%0d_s2_ready", c), s2_ready, 0);
      chk($sformatf("bp_c%0d_req", c), dmem_req, 0);
      chk($sformatf("bp_c%0d_s3_pc", c), s3_pc, 64'h300);
      chk($sformatf("bp_c%0d_s3_full", c), s3_full, 1);
      @(negedge g_clk);
    end
    s3_ready = 1'b1;
    #1;
    chk("bp_release_s2_ready", s2_ready, 1);
    @(negedge g_clk);
    chk("bp_release_s3_pc", s3_pc, 64'h304);
    chk("bp_release_s3_full", s3_full, 1);

    // Flush while idle: slot cleared, offered instruction dropped
    drive_op(LSU_OP_NONE, 64'h79, 64'h0, 64'h308);
    s3_ready = 1'b0;
    flush    = 1'b1;
    @(negedge g_clk);
    chk("flush_idle_s3_full", s3_full, 0);
    chk("flush_idle_s3_pc", s3_pc, 64'h304);
    idle_inputs();

    // Flush during REQ; grant two cycles later; s2 changes meanwhile
    drive_op(LSU_OP_SW, 64'h500, 64'h77, 64'h400);
    #1;
    chk("fr_issue_req", dmem_req, 1);
    @(negedge g_clk);
    flush = 1'b1;
    #1;
    chk("fr_flush_req", dmem_req, 1);
    @(negedge g_clk);
    idle_inputs();
    s2_wdata = 64'h900;
    #1;
    chk("fr_drain_req", dmem_req, 1);
    chk("fr_drain_addr", dmem_addr, 64'h500);
    chk("fr_drain_strb", dmem_strb, 8'h0F);
    chk("fr_drain_wen", dmem_wen, 1);
    chk("fr_drain_s2_ready", s2_ready, 0);
    @(negedge g_clk);
    dmem_gnt = 1'b1;
    #1;
    chk("fr_gnt_req", dmem_req, 1);
    chk("fr_gnt_addr", dmem_addr, 64'h500);
    @(negedge g_clk);
    dmem_gnt = 1'b0;
    chk("fr_after_s3_full", s3_full, 0);
    #1;
    chk("fr_after_req", dmem_req, 0);
    drive_op(LSU_OP_LD, 64'h600, 64'h0, 64'h410);
    dmem_gnt = 1'b1;
    #1;
    chk("fr_idle_req", dmem_req, 1);
    chk("fr_idle_addr", dmem_addr, 64'h600);
    chk("fr_idle_s2_ready", s2_ready, 1);
    @(negedge g_clk);
    chk("fr_idle_s3_full", s3_full, 1);
    chk("fr_idle_s3_wdata", s3_wdata, 64'h600);
    idle_inputs();

    // Flush and grant in the same REQ cycle
    drive_op(LSU_OP_LD, 64'h700, 64'h0, 64'h420);
    @(negedge g_clk);
    flush    = 1'b1;
    dmem_gnt = 1'b1;
    #1;
    chk("fg_req", dmem_req, 1);
    @(negedge g_clk);
    idle_inputs();
    chk("fg_s3_full", s3_full, 0);
    #1;
    chk("fg_back_idle_req", dmem_req, 0);

    // Asynchronous reset while a request is outstanding
    drive_op(LSU_OP_LD, 64'h800, 64'h0, 64'h430);
    @(negedge g_clk);
    #1;
    chk("ar_req_before", dmem_req, 1);
    #2 g_reset = 1'b1;
    #1;
    chk("ar_req", dmem_req, 0);
    chk("ar_s3_full", s3_full, 0);
    chk("ar_s2_ready", s2_ready, 0);
    @(negedge g_clk);
    g_reset = 1'b0;
    s2_valid = 1'b0;
    #1;
    chk("ar_after_req", dmem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
